// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, drives a req/ready instruction memory, honours freeze and branch redirect.
module if_stage #(
    parameter logic [31:0] PC_RESET = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        br_taken,
    input  logic [31:0] br_offset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    // FETCH: request outstanding at pc.
    // HOLD: a word arrived during freeze and waits in hold_instr_q.
    // DRAIN: wrong-path request still pending; must be completed, then dropped.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] drain_addr_q;
    logic [31:0] hold_instr_q;
    logic [31:0] pc_out_q;
    logic [31:0] instr_q;
    logic        valid_q;

    logic [31:0] br_byte_off;
    logic [31:0] br_target;
    logic [31:0] pc_inc;

    // Branch target is relative to the instruction in decode (pc_out = its address + 4).
    assign br_byte_off = br_offset << 2;
    assign br_target   = pc_out_q + br_byte_off;
    assign pc_inc      = pc_q + 32'd4;

    // Request is held through DRAIN so the memory handshake is never withdrawn.
    assign imem_req  = !rst && (state_q != HOLD);
    assign imem_addr = (state_q == DRAIN) ? drain_addr_q : pc_q;

    assign pc_out          = pc_out_q;
    assign instruction_out = instr_q;
    assign valid_out       = valid_q;

    // Fetch FSM and IF/ID register; priority is rst > br_taken > freeze > advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= PC_RESET;
            drain_addr_q <= 32'd0;
            hold_instr_q <= 32'd0;
            pc_out_q     <= 32'd0;
            instr_q      <= 32'd0;
            valid_q      <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (br_taken) begin
                        pc_q    <= br_target;
                        instr_q <= 32'd0;
                        valid_q <= 1'b0;
                        if (!imem_ready) begin
                            drain_addr_q <= pc_q;
                            state_q      <= DRAIN;
                        end
                    end else if (imem_ready) begin
                        if (!freeze) begin
                            pc_out_q <= pc_inc;
                            instr_q  <= imem_rdata;
                            valid_q  <= 1'b1;
                            pc_q     <= pc_inc;
                        end else begin
                            hold_instr_q <= imem_rdata;
                            state_q      <= HOLD;
                        end
                    end else if (!freeze) begin
                        instr_q <= 32'd0;
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (br_taken) begin
                        pc_q         <= br_target;
                        hold_instr_q <= 32'd0;
                        instr_q      <= 32'd0;
                        valid_q      <= 1'b0;
                        state_q      <= FETCH;
                    end else if (!freeze) begin
                        pc_out_q <= pc_inc;
                        instr_q  <= hold_instr_q;
                        valid_q  <= 1'b1;
                        pc_q     <= pc_inc;
                        state_q  <= FETCH;
                    end
                end
                DRAIN: begin
                    instr_q <= 32'd0;
                    valid_q <= 1'b0;
                    if (br_taken) begin
                        pc_q <= br_target;
                    end
                    if (imem_ready) begin
                        state_q <= FETCH;
                    end
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Testbench for if_stage: directed scenarios plus a randomized run
// checked against a program-order model of the fetched stream.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        br_taken;
    logic [31:0] br_offset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;

    int total;
    int bad;

    int   lat;
    bit   rand_mode;
    bit   rnd_ready;
    int   wcnt;

    if_stage #(.PC_RESET(32'd0)) dut (
        .clk(clk),
        .rst(rst),
        .freeze(freeze),
        .br_taken(br_taken),
        .br_offset(br_offset),
        .imem_req(imem_req),
        .imem_addr(imem_addr),
        .imem_rdata(imem_rdata),
        .imem_ready(imem_ready),
        .pc_out(pc_out),
        .instruction_out(instruction_out),
        .valid_out(valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: word i holds i+0x100; fixed or random wait states.
    always @(posedge clk) begin
        if (!imem_req || imem_ready) wcnt <= 0;
        else wcnt <= wcnt + 1;
    end

    assign imem_ready = imem_req &&
        (rand_mode ? rnd_ready : (wcnt >= lat));
    assign imem_rdata = imem_ready ?
        ((imem_addr >> 2) + 32'h100) : 32'hDEADBEEF;

    initial begin
        #2000000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        rnd_ready = ($urandom_range(3) != 0);
        #1;
    endtask

    task automatic do_reset(input int l, input bit rm);
        lat = l;
        rand_mode = rm;
        rst = 1'b1;
        freeze = 1'b0;
        br_taken = 1'b0;
        br_offset = 32'd0;
        #1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (imem_req !== 1'b0) begin
                bad++;
                $display("FAIL rst_req: got %b want 0", imem_req);
            end
        end
        total++;
        if ({pc_out, instruction_out, valid_out} !== 65'd0) begin
            bad++;
            $display("FAIL rst_out: got %h %h %b want 0 0 0",
                     pc_out, instruction_out, valid_out);
        end
        rst = 1'b0;
        #1;
    endtask

    task automatic wait_valid(input string nm);
        int n;
        n = 0;
        while (!valid_out && n < 12) begin
            tick();
            n++;
        end
        total++;
        if (pc_out !== 32'd4 || instruction_out !== 32'h100 ||
            valid_out !== 1'b1) begin
            bad++;
            $display("FAIL %s: got %h %h %b want 4 100 1",
                     nm, pc_out, instruction_out, valid_out);
        end
    endtask

    task automatic test_reset();
        do_reset(0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (pc_out !== 32'(4 * (i + 1)) ||
                instruction_out !== 32'(32'h100 + i) ||
                valid_out !== 1'b1) begin
                bad++;
                $display("FAIL reset_seq%0d: got %h %h %b want %h %h 1",
                         i, pc_out, instruction_out, valid_out,
                         4 * (i + 1), 32'h100 + i);
            end
        end
    endtask

    task automatic test_freeze();
        do_reset(0, 1'b0);
        tick();
        tick();
        freeze = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (pc_out !== 32'd8 || instruction_out !== 32'h101 ||
                valid_out !== 1'b1 || imem_req !== 1'b0) begin
                bad++;
                $display("FAIL freeze_hold%0d: got %h %h %b req %b want 8 101 1 req 0",
                         i, pc_out, instruction_out, valid_out, imem_req);
            end
        end
        freeze = 1'b0;
        tick();
        total++;
        if (pc_out !== 32'd12 || instruction_out !== 32'h102 ||
            valid_out !== 1'b1) begin
            bad++;
            $display("FAIL freeze_rel: got %h %h %b want c 102 1",
                     pc_out, instruction_out, valid_out);
        end
        tick();
        total++;
        if (pc_out !== 32'd16 || instruction_out !== 32'h103) begin
            bad++;
            $display("FAIL freeze_next: got %h %h want 10 103",
                     pc_out, instruction_out);
        end
    endtask

    task automatic test_branch();
        do_reset(0, 1'b0);
        tick();
        tick();
        br_taken = 1'b1;
        br_offset = 32'd3;
        tick();
        br_taken = 1'b0;
        total++;
        if (valid_out !== 1'b0 || instruction_out !== 32'd0 ||
            imem_req !== 1'b1 || imem_addr !== 32'd20) begin
            bad++;
            $display("FAIL br_squash: got v%b %h req %b addr %h want v0 0 req 1 addr 14",
                     valid_out, instruction_out, imem_req, imem_addr);
        end
        tick();
        total++;
        if (pc_out !== 32'd24 || instruction_out !== 32'h105 ||
            valid_out !== 1'b1) begin
            bad++;
            $display("FAIL br_target: got %h %h %b want 18 105 1",
                     pc_out, instruction_out, valid_out);
        end
    endtask

    task automatic test_drain();
        int n;
        do_reset(2, 1'b0);
        wait_valid("drain_first");
        br_taken = 1'b1;
        br_offset = 32'hFFFF_FFFF;
        tick();
        br_taken = 1'b0;
        n = 0;
        while (imem_req && imem_addr == 32'd4 && n < 8) begin
            total++;
            if (valid_out !== 1'b0 || instruction_out !== 32'd0) begin
                bad++;
                $display("FAIL drain_nop: got %b %h want 0 0",
                         valid_out, instruction_out);
            end
            tick();
            n++;
        end
        total++;
        if (n < 2 || imem_addr !== 32'd0 || imem_req !== 1'b1 ||
            valid_out !== 1'b0 || instruction_out !== 32'd0) begin
            bad++;
            $display("FAIL drain_exit: got waits %0d addr %h req %b v%b %h want waits>=2 addr 0 req 1 v0 0",
                     n, imem_addr, imem_req, valid_out, instruction_out);
        end
        wait_valid("drain_target");
    endtask

    task automatic test_hold_branch();
        do_reset(0, 1'b0);
        tick();
        tick();
        freeze = 1'b1;
        tick();
        total++;
        if (instruction_out !== 32'h101 || imem_req !== 1'b0) begin
            bad++;
            $display("FAIL hb_hold: got %h req %b want 101 req 0",
                     instruction_out, imem_req);
        end
        br_taken = 1'b1;
        br_offset = 32'd2;
        tick();
        br_taken = 1'b0;
        freeze = 1'b0;
        total++;
        if (valid_out !== 1'b0 || instruction_out !== 32'd0 ||
            imem_req !== 1'b1 || imem_addr !== 32'd16) begin
            bad++;
            $display("FAIL hb_squash: got v%b %h req %b addr %h want v0 0 req 1 addr 10",
                     valid_out, instruction_out, imem_req, imem_addr);
        end
        tick();
        total++;
        if (pc_out !== 32'd20 || instruction_out !== 32'h104 ||
            valid_out !== 1'b1) begin
            bad++;
            $display("FAIL hb_target: got %h %h %b want 14 104 1",
                     pc_out, instruction_out, valid_out);
        end
    endtask

    task automatic test_reset_mid();
        do_reset(2, 1'b0);
        wait_valid("rm_first");
        total++;
        if (imem_req !== 1'b1 || imem_ready !== 1'b0) begin
            bad++;
            $display("FAIL rm_pending: got req %b rdy %b want 1 0",
                     imem_req, imem_ready);
        end
        rst = 1'b1;
        #1;
        total++;
        if (imem_req !== 1'b0) begin
            bad++;
            $display("FAIL rm_req: got %b want 0", imem_req);
        end
        tick();
        total++;
        if ({pc_out, instruction_out, valid_out} !== 65'd0) begin
            bad++;
            $display("FAIL rm_out: got %h %h %b want 0 0 0",
                     pc_out, instruction_out, valid_out);
        end
        rst = 1'b0;
        #1;
        total++;
        if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            bad++;
            $display("FAIL rm_pc: got req %b addr %h want 1 0",
                     imem_req, imem_addr);
        end
        wait_valid("rm_restart");
    endtask

    // Reference: instructions appear in program order starting at the reset PC;
    // a taken branch squashes the next slot and restarts the order at its target;
    // a freeze leaves IF/ID untouched; a pending request keeps its address.
    task automatic test_random();
        logic [31:0] exp_next;
        logic [31:0] p_pc, p_ins, p_off, p_addr;
        bit          p_val, p_br, p_frz, p_req, p_rdy;
        int          nvalid;
        do_reset(0, 1'b1);
        exp_next = 32'd0;
        nvalid = 0;
        p_pc = pc_out; p_ins = instruction_out; p_val = valid_out;
        p_br = 1'b0; p_frz = 1'b0; p_off = 32'd0;
        p_req = imem_req; p_rdy = imem_ready; p_addr = imem_addr;
        for (int c = 0; c < 600; c++) begin
            tick();
            if (p_br) begin
                total++;
                if (valid_out !== 1'b0 || instruction_out !== 32'd0) begin
                    bad++;
                    $display("FAIL rnd_br c%0d: got v%b %h want v0 0",
                             c, valid_out, instruction_out);
                end
                exp_next = p_pc + (p_off << 2);
            end else if (p_frz) begin
                total++;
                if (pc_out !== p_pc || instruction_out !== p_ins ||
                    valid_out !== p_val) begin
                    bad++;
                    $display("FAIL rnd_frz c%0d: got %h %h %b want %h %h %b",
                             c, pc_out, instruction_out, valid_out,
                             p_pc, p_ins, p_val);
                end
            end else if (valid_out) begin
                total++;
                if (pc_out !== exp_next + 32'd4 ||
                    instruction_out !== (exp_next >> 2) + 32'h100) begin
                    bad++;
                    $display("FAIL rnd_seq c%0d: got %h %h want %h %h",
                             c, pc_out, instruction_out, exp_next + 32'd4,
                             (exp_next >> 2) + 32'h100);
                end
                exp_next = exp_next + 32'd4;
                nvalid++;
            end else begin
                total++;
                if (instruction_out !== 32'd0) begin
                    bad++;
                    $display("FAIL rnd_nop c%0d: got %h want 0",
                             c, instruction_out);
                end
            end
            if (p_req && !p_rdy) begin
                total++;
                if (imem_req !== 1'b1 || imem_addr !== p_addr) begin
                    bad++;
                    $display("FAIL rnd_hs c%0d: got req %b addr %h want 1 %h",
                             c, imem_req, imem_addr, p_addr);
                end
            end
            br_taken = valid_out && ($urandom_range(7) == 0);
            br_offset = 32'($urandom_range(16)) - 32'd8;
            freeze = ($urandom_range(3) == 0);
            #1;
            p_pc = pc_out; p_ins = instruction_out; p_val = valid_out;
            p_br = br_taken; p_frz = freeze; p_off = br_offset;
            p_req = imem_req; p_rdy = imem_ready; p_addr = imem_addr;
        end
        br_taken = 1'b0;
        freeze = 1'b0;
        total++;
        if (nvalid < 100) begin
            bad++;
            $display("FAIL rnd_progress: got %0d instrs want >=100", nvalid);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        lat = 0;
        rand_mode = 1'b0;
        rnd_ready = 1'b1;
        rst = 1'b1;
        freeze = 1'b0;
        br_taken = 1'b0;
        br_offset = 32'd0;
        test_reset();
        test_freeze();
        test_branch();
        test_drain();
        test_hold_branch();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
